// File: rtl/seq_detect_stream_ctrl.sv
// Serial pattern detector over a word stream: each accepted word is scanned MSB-first,
// one bit per cycle, and a word of per-bit match flags is returned through a ready/valid port.
module seq_detect_stream_ctrl #(
  parameter int WIDTH   = 16,
  parameter int PAT_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_word,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_word,
  output logic [7:0]         match_count,
  output logic               busy
);

  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FILL_W = 4;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   word_q;
  logic [IDX_W-1:0]   idx;
  logic [PAT_LEN-2:0] hist;
  logic [PAT_LEN-1:0] pattern;
  logic [PAT_LEN-1:0] window;
  logic [FILL_W-1:0]  fill;
  logic               cur_bit;
  logic               match;
  logic               accept;
  logic               load;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] v);
    return (v >= FILL_MAX) ? FILL_MAX : v + FILL_W'(1);
  endfunction

  assign accept  = (state == IDLE) && in_valid;
  assign load    = (state == IDLE) && cfg_load;
  assign cur_bit = word_q[idx];
  assign window  = {hist, cur_bit};
  // Only a full window of real history may match; fill gates out reset zeros.
  assign match   = (window == pattern) && (fill >= FILL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (idx == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q      <= '0;
      idx         <= '0;
      hist        <= '0;
      pattern     <= '0;
      fill        <= '0;
      out_word    <= '0;
      match_count <= '0;
    end else begin
      // A load and a word in the same cycle both apply; the word then scans fresh history.
      if (load) begin
        pattern <= cfg_pattern;
        hist    <= '0;
        fill    <= '0;
      end
      if (accept) begin
        word_q   <= in_word;
        idx      <= IDX_W'(WIDTH - 1);
        out_word <= '0;
      end
      if (state == SHIFT) begin
        hist          <= window[PAT_LEN-2:0];
        fill          <= sat_fill(fill);
        out_word[idx] <= match;
        idx           <= idx - IDX_W'(1);
        if (match) match_count <= sat_inc8(match_count);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_stream_ctrl.sv
// Scoreboard bench for seq_detect_stream_ctrl: directed scenarios plus random traffic
// against a sliding-window reference model.
module tb_seq_detect_stream_ctrl;

  localparam int W = 16;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_word;
  logic         cfg_load;
  logic [P-1:0] cfg_pattern;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_word;
  logic [7:0]   match_count;
  logic         busy;

  seq_detect_stream_ctrl #(.WIDTH(W), .PAT_LEN(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .match_count(match_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] w;
    logic [7:0]   cnt;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           rdy_mode = 1;
  logic [W-1:0] last_word = '0;
  logic [7:0]   last_cnt = '0;

  // Reference model: recent bits kept as a list, compared as an integer window.
  bit           mhist[$];
  int           m_pat = 0;
  int           m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function void model_reset();
    mhist.delete();
    m_pat = 0;
    m_cnt = 0;
  endfunction

  function void model_load(input logic [P-1:0] pat);
    mhist.delete();
    m_pat = int'(pat);
  endfunction

  function void model_word(input logic [W-1:0] w);
    exp_t e;
    int   v;
    e.w = '0;
    for (int i = W - 1; i >= 0; i--) begin
      mhist.push_back(w[i]);
      if (mhist.size() > P) void'(mhist.pop_front());
      if (mhist.size() == P) begin
        v = 0;
        foreach (mhist[j]) v = (v << 1) | int'(mhist[j]);
        if (v == m_pat) begin
          e.w[i] = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
    e.cnt = 8'(m_cnt);
    exp_q.push_back(e);
  endfunction

  // Offer a word and/or a pattern load; the model advances on the accepting edge.
  task automatic xfer(input bit do_word, input logic [W-1:0] w, input bit do_load,
                      input logic [P-1:0] pat);
    int n = 0;
    in_valid    = do_word;
    in_word     = w;
    cfg_load    = do_load;
    cfg_pattern = pat;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) break;
    end
    if (n > 300) begin
      chk("xfer_timeout", 32'(n), 32'd0);
      @(posedge clk);
    end else begin
      @(posedge clk);
      if (do_load) model_load(pat);
      if (do_word) model_word(w);
    end
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_word"}, 32'(out_word), 32'd0);
    chk({tag, "_match_count"}, 32'(match_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops one expectation per output handshake and checks hold stability.
  initial begin
    exp_t         e;
    bit           held = 0;
    logic [W-1:0] held_word = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_word", 32'(out_word), 32'(held_word));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", 32'(out_word), 32'(e.w));
            chk("match_count", 32'(match_count), 32'(e.cnt));
          end
          last_word = out_word;
          last_cnt  = match_count;
        end
        held      = out_valid && !out_ready;
        held_word = out_word;
      end
    end
  end

  initial begin
    int           k;
    logic [W-1:0] hold_w;
    rst = 1'b1; in_valid = 1'b0; in_word = '0; cfg_load = 1'b0; cfg_pattern = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    model_reset();

    // Basic detection with output latency
    xfer(1, 16'hDDDD, 1, 4'b1101);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("latency", 32'(k), 32'd16);
    drain();
    chk("basic_word", 32'(last_word), 32'h1111);
    chk("basic_count", 32'(last_cnt), 32'd4);

    // Match spanning a word boundary
    xfer(1, 16'h0001, 0, '0);
    drain();
    chk("span_first", 32'(last_word), 32'h0000);
    xfer(1, 16'hA000, 0, '0);
    drain();
    chk("span_second", 32'(last_word), 32'h2000);

    // Pattern load clears history
    xfer(1, 16'h0001, 0, '0);
    drain();
    xfer(0, '0, 1, 4'b1101);
    xfer(1, 16'hA000, 0, '0);
    drain();
    chk("clear_word", 32'(last_word), 32'h0000);

    // Backpressure in DONE
    rdy_mode = 2;
    xfer(1, 16'h0D0D, 0, '0);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp_reach_done", 32'(out_valid), 32'd1);
    hold_w   = out_word;
    in_valid = 1'b1;
    in_word  = 16'hBEEF;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_stable", 32'(out_word), 32'(hold_w));
    end
    rdy_mode = 1;
    xfer(1, 16'hBEEF, 0, '0);
    drain();

    // Reset in the middle of SHIFT
    xfer(1, 16'hDDDD, 0, '0);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    xfer(1, 16'hDDDD, 1, 4'b1101);
    drain();
    chk("after_reset_word", 32'(last_word), 32'h1111);
    chk("after_reset_count", 32'(last_cnt), 32'd4);

    // Random traffic with random backpressure and pattern changes
    rdy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       xfer(0, '0, 1, P'($urandom));
        1:       xfer(1, W'($urandom), 1, P'($urandom));
        default: xfer(1, W'($urandom), 0, '0);
      endcase
    end
    drain();

    // Match counter saturation
    rdy_mode = 1;
    xfer(0, '0, 1, 4'b1101);
    for (int i = 0; i < 70; i++) xfer(1, 16'hDDDD, 0, '0);
    drain();
    chk("saturated_count", 32'(last_cnt), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
